// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - four-symbol UART combination lock with retry lockout
// Optional auto-relock timer: define LOCK_SEQUENCER_RELOCK_TIMEOUT_EN.
module lock_sequencer #(
    parameter logic [7:0] CODE           = 8'b00011011,
    parameter int         MAX_TRIES      = 3,
    parameter int         LOCKOUT_CYCLES = 500000000,
    parameter int         RELOCK_CYCLES  = 1000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       unlocked,
    output logic       lockout,
    output logic       fail_tick,
    output logic [2:0] digit_count
);

    localparam int TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_CHECK    = 2'd1,
        S_UNLOCKED = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    buffer, buffer_nx;
    logic [2:0]    count, count_nx;
    logic [2:0]    attempts, attempts_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          fail_nx;

    logic       is_sym;
    logic       is_clr;
    logic [1:0] sym;
    logic [2:0] attempts_inc;

    // 'a'..'d' (0x61..0x64) map to 0..3 via the low two bits minus one.
    assign is_sym = rx_valid && (rx_data >= 8'h61) && (rx_data <= 8'h64);
    assign is_clr = rx_valid && (rx_data == 8'h65);
    assign sym    = rx_data[1:0] - 2'd1;

    // Saturating increment so the attempt counter can never wrap.
    assign attempts_inc = (attempts == 3'd7) ? attempts : attempts + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOCKED;
            buffer    <= 8'd0;
            count     <= 3'd0;
            attempts  <= 3'd0;
            timer     <= '0;
            fail_tick <= 1'b0;
        end else begin
            state     <= state_nx;
            buffer    <= buffer_nx;
            count     <= count_nx;
            attempts  <= attempts_nx;
            timer     <= timer_nx;
            fail_tick <= fail_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        buffer_nx   = buffer;
        count_nx    = count;
        attempts_nx = attempts;
        timer_nx    = timer;
        fail_nx     = 1'b0;

        case (state)
            S_LOCKED: begin
                if (is_sym) begin
                    buffer_nx = {buffer[5:0], sym};
                    count_nx  = count + 3'd1;
                    if (count == 3'd3) begin
                        state_nx = S_CHECK;
                    end
                end else if (is_clr) begin
                    buffer_nx = 8'd0;
                    count_nx  = 3'd0;
                end
            end

            S_CHECK: begin
                buffer_nx = 8'd0;
                count_nx  = 3'd0;
                if (buffer == CODE) begin
                    state_nx    = S_UNLOCKED;
                    attempts_nx = 3'd0;
`ifdef LOCK_SEQUENCER_RELOCK_TIMEOUT_EN
                    timer_nx    = TW'(RELOCK_CYCLES - 1);
`endif
                end else begin
                    fail_nx     = 1'b1;
                    attempts_nx = attempts_inc;
                    if (attempts_inc >= 3'(MAX_TRIES)) begin
                        state_nx = S_LOCKOUT;
                        timer_nx = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_nx = S_LOCKED;
                    end
                end
            end

            S_UNLOCKED: begin
`ifdef LOCK_SEQUENCER_RELOCK_TIMEOUT_EN
                if (is_clr || (timer == '0)) begin
                    state_nx = S_LOCKED;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer - 1'b1;
                end
`else
                if (is_clr) begin
                    state_nx = S_LOCKED;
                end
`endif
            end

            S_LOCKOUT: begin
                if (timer == '0) begin
                    state_nx    = S_LOCKED;
                    attempts_nx = 3'd0;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end

            default: begin
                state_nx = S_LOCKED;
            end
        endcase
    end

    assign unlocked    = (state == S_UNLOCKED);
    assign lockout     = (state == S_LOCKOUT);
    assign digit_count = count;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - directed self-checking bench for lock_sequencer
// Honours LOCK_SEQUENCER_RELOCK_TIMEOUT_EN to select the expected relock behaviour.
module tb_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       unlocked;
    logic       lockout;
    logic       fail_tick;
    logic [2:0] digit_count;

    int errors = 0;
    int checks = 0;
    int fails_seen = 0;

    lock_sequencer #(
        .CODE          (8'b00011011),
        .MAX_TRIES     (3),
        .LOCKOUT_CYCLES(100),
        .RELOCK_CYCLES (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .unlocked   (unlocked),
        .lockout    (lockout),
        .fail_tick  (fail_tick),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // Counts pulses on the rising edge, where the registered value is stable.
    always @(posedge clk) begin
        if (fail_tick) fails_seen++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge; presents the byte for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic enter(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Raises rst between clock edges and checks outputs before any rising edge.
    task automatic async_reset_check(input string tag);
        #1 rst = 1'b1;
        #1;
        check({tag, "_unlocked"}, unlocked, 0);
        check({tag, "_lockout"}, lockout, 0);
        check({tag, "_fail"}, fail_tick, 0);
        check({tag, "_dc"}, digit_count, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int f0;
        int n;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_unlocked", unlocked, 0);
        check("rst_lockout", lockout, 0);
        check("rst_fail", fail_tick, 0);
        check("rst_dc", digit_count, 0);
        rst = 1'b0;

        // Correct code, digit counting, two-edge unlock latency.
        f0 = fails_seen;
        send_byte("a"); check("dc1", digit_count, 1);
        send_byte("b"); check("dc2", digit_count, 2);
        send_byte("c"); check("dc3", digit_count, 3);
        send_byte("d"); check("dc4", digit_count, 4);
        check("check_not_yet_unlocked", unlocked, 0);
        send_byte("a");
        check("unlock_latency", unlocked, 1);
        check("dc_after_unlock", digit_count, 0);
        check("no_fail_pulse", fails_seen - f0, 0);
`ifdef LOCK_SEQUENCER_RELOCK_TIMEOUT_EN
        n = 0;
        while (unlocked && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("relock_cycles", n, 50);
`else
        repeat (1000) @(negedge clk);
        check("unlock_persists", unlocked, 1);
        send_byte("b");
        check("sym_ignored_unlocked", digit_count, 0);
        check("still_unlocked", unlocked, 1);
        send_byte("e");
        check("clear_relocks", unlocked, 0);
`endif

        // Clear mid-entry then correct code.
        do_reset();
        enter("ab");
        check("pre_clear_dc", digit_count, 2);
        send_byte("e");
        check("clear_dc", digit_count, 0);
        enter("abcd");
        @(negedge clk);
        check("unlock_after_clear", unlocked, 1);

        // Non-code bytes interleaved are ignored.
        do_reset();
        send_byte(8'h41); send_byte("a");
        send_byte(8'h00); send_byte("b");
        send_byte(8'hFF);
        check("junk_ignored_dc", digit_count, 2);
        send_byte("c");
        check("junk_dc3", digit_count, 3);
        send_byte("d");
        @(negedge clk);
        check("junk_unlock", unlocked, 1);

        // Three wrong codes: pulses, lockout, ignored input, exact duration.
        do_reset();
        f0 = fails_seen;
        enter("abdc");
        @(negedge clk);
        check("fail_pulse_high", fail_tick, 1);
        check("first_fail_locked", lockout, 0);
        @(negedge clk);
        check("fail_pulse_one_cycle", fail_tick, 0);
        enter("abdc");
        @(negedge clk);
        enter("abdc");
        @(negedge clk);
        check("lockout_entered", lockout, 1);
        send_byte("e");
        enter("abcd");
        check("lockout_ignores_dc", digit_count, 0);
        check("lockout_held", lockout, 1);
        check("lockout_not_unlocked", unlocked, 0);
        n = 0;
        while (lockout && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("lockout_duration", n, 95);
        check("fail_pulse_count", fails_seen - f0, 3);
        enter("abcd");
        @(negedge clk);
        check("unlock_after_lockout", unlocked, 1);

        // Clear keeps the attempt count; then reset during lockout.
        do_reset();
        enter("abdc"); @(negedge clk);
        enter("abdc"); @(negedge clk);
        enter("ae");
        enter("abdc"); @(negedge clk);
        check("attempts_survive_clear", lockout, 1);
        async_reset_check("rst_lockout");

        // Reset mid-entry.
        enter("ab");
        check("mid_entry_dc", digit_count, 2);
        async_reset_check("rst_entry");
        send_byte("a");
        check("first_after_reset", digit_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
